// File: rtl/flatten_stream_ctrl.sv
// Flatten-stage sequencer: pulses the flatten block and captures its vector.
// It then streams the vector to the dense layer as LANES-wide valid/ready beats.
module flatten_stream_ctrl #(
  parameter int IN_WIDTH    = 4,
  parameter int IN_CHANNELS = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  localparam int N          = IN_WIDTH * IN_WIDTH * IN_CHANNELS,
  localparam int FLAT_BITS  = N * DATA_WIDTH,
  localparam int BEATS      = (N + LANES - 1) / LANES,
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          flat_enable,
  input  logic [FLAT_BITS-1:0]          flat_vector,
  output logic                          busy,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_keep,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [BW-1:0]                 out_beat,
  output logic                          done
);

  localparam int BEAT_BITS = LANES * DATA_WIDTH;
  localparam int PAD_BITS  = BEATS * BEAT_BITS;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, FLAT, LOAD, STREAM, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [FLAT_BITS-1:0]   cap_reg;
  logic [BW-1:0]          beat_reg, beat_next;
  logic [PAD_BITS-1:0]    padded;
  logic [BEAT_BITS-1:0]   beat_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cap_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (state_reg == LOAD)
        cap_reg <= flat_vector;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE:   if (start) state_next = FLAT;
      FLAT:   state_next = LOAD;
      LOAD: begin
        beat_next  = '0;
        state_next = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = DONE;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign flat_enable = (state_reg == FLAT);
  assign busy        = (state_reg != IDLE);
  assign out_valid   = (state_reg == STREAM);
  assign done        = (state_reg == DONE);
  assign out_beat    = beat_reg;
  assign out_last    = out_valid && (beat_reg == LAST_BEAT);

  // Zero-pad the capture so the final partial beat can be sliced uniformly.
  assign padded   = PAD_BITS'(cap_reg);
  assign beat_sel = padded[int'(beat_reg) * BEAT_BITS +: BEAT_BITS];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic lane_live;
    assign lane_live = out_valid && ((int'(beat_reg) * LANES + gi) < N);
    assign out_keep[gi] = lane_live;
    assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      lane_live ? beat_sel[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

// File: tb/tb_flatten_stream_ctrl.sv
// Scoreboard bench for flatten_stream_ctrl: a 4-lane and a 5-lane instance, expected
// beats queued at stimulus time and compared as each beat is accepted.
module tb_flatten_stream_ctrl;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          beat;
  } exp_t;

  logic clk = 0;
  always #5 clk = ~clk;

  logic         rst = 1;
  logic         start = 0, start5 = 0;
  logic [255:0] fv = '0, fv5 = '0, fv_init;
  logic         out_ready = 1, out_ready5 = 1;

  logic         flat_enable, busy, out_valid, out_last, done;
  logic [31:0]  out_data;
  logic [3:0]   out_keep;
  logic [2:0]   out_beat;

  logic         flat_enable5, busy5, out_valid5, out_last5, done5;
  logic [39:0]  out_data5;
  logic [4:0]   out_keep5;
  logic [2:0]   out_beat5;

  int vectors = 0, miscompares = 0;
  int fe4 = 0, dn4 = 0, fe5 = 0, dn5 = 0;
  exp_t q4[$], q5[$];
  exp_t m4, m5;
  logic        held_v4 = 0;
  logic [31:0] hd4;
  logic [3:0]  hk4;
  logic [2:0]  hb4;
  logic        hl4;

  flatten_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .flat_enable(flat_enable),
    .flat_vector(fv), .busy(busy), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_beat(out_beat), .done(done)
  );

  flatten_stream_ctrl #(.LANES(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .flat_enable(flat_enable5),
    .flat_vector(fv5), .busy(busy5), .out_data(out_data5), .out_keep(out_keep5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_last(out_last5),
    .out_beat(out_beat5), .done(done5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_pass(input logic [255:0] v, input int lanes);
    int beats = (32 + lanes - 1) / lanes;
    for (int b = 0; b < beats; b++) begin
      exp_t e;
      e.data = '0;
      e.keep = '0;
      for (int l = 0; l < lanes; l++) begin
        int idx = b * lanes + l;
        if (idx < 32) begin
          e.data[l*8 +: 8] = v[idx*8 +: 8];
          e.keep[l] = 1'b1;
        end
      end
      e.last = (b == beats - 1);
      e.beat = b;
      if (lanes == 4) q4.push_back(e);
      else q5.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one tick after edge 0 (the edge that samples start), i.e. inside cycle 1.
  task automatic pulse_start(input bit five);
    step();
    if (five) start5 = 1; else start = 1;
    step();
    start = 0;
    start5 = 0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !busy5) break;
    end
    check("idle_timeout", {62'd0, busy, busy5}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held_v4 = 0;
    end else begin
      if (flat_enable) fe4++;
      if (done) dn4++;
      if (!out_valid) check("last_without_valid", out_last, 0);
      if (held_v4) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd4);
        check("hold_keep", out_keep, hk4);
        check("hold_beat", out_beat, hb4);
        check("hold_last", out_last, hl4);
      end
      if (out_valid && out_ready) begin
        if (q4.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          m4 = q4.pop_front();
          check("beat_data", out_data, m4.data);
          check("beat_keep", out_keep, m4.keep);
          check("beat_last", out_last, m4.last);
          check("beat_index", out_beat, m4.beat);
        end
      end
      held_v4 = out_valid && !out_ready;
      hd4 = out_data; hk4 = out_keep; hb4 = out_beat; hl4 = out_last;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (flat_enable5) fe5++;
      if (done5) dn5++;
      if (out_valid5 && out_ready5) begin
        if (q5.size() == 0) begin
          check("extra_beat5", 1, 0);
        end else begin
          m5 = q5.pop_front();
          check("beat5_data", out_data5, m5.data);
          check("beat5_keep", out_keep5, m5.keep);
          check("beat5_last", out_last5, m5.last);
          check("beat5_index", out_beat5, m5.beat);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, d0, n;
    logic [3:0] pat;
    for (int e = 0; e < 32; e++) fv_init[e*8 +: 8] = 8'(e + 1);
    fv = fv_init;
    fv5 = fv_init;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_outputs", {flat_enable, busy, out_valid, out_last, done}, 0);
    check("rst_data", {out_data, out_keep, out_beat}, 0);
    step();
    rst = 0;

    // Nominal pass with cycle-exact timing
    push_pass(fv, 4);
    pulse_start(0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("c%0d_flat_enable", c), flat_enable, c == 1);
      check($sformatf("c%0d_valid", c), out_valid, (c >= 3 && c <= 10));
      check($sformatf("c%0d_last", c), out_last, c == 10);
      check($sformatf("c%0d_done", c), done, c == 11);
      check($sformatf("c%0d_busy", c), busy, c <= 11);
    end
    check("pass1_drain", q4.size(), 0);
    check("pass1_fe_count", fe4, 1);
    check("pass1_done_count", dn4, 1);

    // Five lanes: last beat is partial
    push_pass(fv5, 5);
    pulse_start(1);
    wait_idle(100);
    check("lanes5_drain", q5.size(), 0);
    check("lanes5_done_count", dn5, 1);

    // Backpressure 1,0,0,1 repeating
    pat = 4'b1001;
    push_pass(fv, 4);
    pulse_start(0);
    for (int k = 0; k < 200; k++) begin
      step();
      out_ready = pat[k % 4];
      if (!busy) break;
    end
    out_ready = 1;
    check("bp_idle", busy, 0);
    check("bp_drain", q4.size(), 0);

    // start during STREAM and DONE is ignored; start right after done is accepted
    for (int e = 0; e < 32; e++) fv[e*8 +: 8] = 8'($urandom_range(0, 255));
    f0 = fe4; d0 = dn4;
    push_pass(fv, 4);
    pulse_start(0);                 // cycle 1
    repeat (4) step();              // cycle 5 (STREAM)
    start = 1;
    step();
    start = 0;                      // cycle 6
    repeat (5) step();              // cycle 11 (DONE)
    start = 1;
    step();
    start = 0;                      // cycle 12
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);
    check("ignored_fe_count", fe4 - f0, 1);
    check("ignored_done_count", dn4 - d0, 1);
    check("ignored_drain", q4.size(), 0);
    push_pass(fv, 4);
    start = 1;                      // sampled at end of cycle 12
    step();
    start = 0;
    wait_idle(100);
    check("restart_fe_count", fe4 - f0, 2);
    check("restart_done_count", dn4 - d0, 2);
    check("restart_drain", q4.size(), 0);

    // Reset mid-stream at beat 3
    fv = fv_init;
    d0 = dn4;
    push_pass(fv, 4);
    pulse_start(0);
    for (n = 0; n < 50; n++) begin
      step();
      if (out_valid && out_beat == 3) break;
    end
    check("reach_beat3", n < 50, 1);
    rst = 1;
    out_ready = 0;
    step();
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    check("abort_outputs", {flat_enable, busy, out_valid, out_last, done}, 0);
    check("abort_data", {out_data, out_keep, out_beat}, 0);
    check("abort_left_beats", q4.size(), 5);
    check("abort_no_done", dn4 - d0, 0);
    q4.delete();
    push_pass(fv, 4);
    pulse_start(0);
    wait_idle(100);
    check("after_abort_drain", q4.size(), 0);
    check("after_abort_done", dn4 - d0, 1);

    // flat_vector changes after LOAD must not affect the stream
    push_pass(fv, 4);
    pulse_start(0);                 // cycle 1
    step();                         // cycle 2 (LOAD)
    step();                         // cycle 3
    fv = '1;
    wait_idle(100);
    check("late_change_drain", q4.size(), 0);
    fv = fv_init;

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flatten_stream_ctrl.md
Name: flatten_stream_ctrl

Overview:
Sequencer for the flatten stage, sitting between the last pooling layer and the first dense layer. On a start pulse it fires the flatten block's enable for one cycle and captures the flattened vector one cycle later. It then streams the vector to the dense layer as fixed-width multi-element beats over a valid/ready handshake, and pulses done after the final beat is accepted.

Parameters:
IN_WIDTH, 4, feature-map side length
IN_CHANNELS, 2, feature-map channel count
DATA_WIDTH, 8, bits per element
LANES, 4, elements per output beat
Derived: N = IN_WIDTH*IN_WIDTH*IN_CHANNELS; FLAT_BITS = N*DATA_WIDTH; BEATS = ceil(N/LANES); BW = max(1, clog2(BEATS))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request one flatten+stream pass; sampled only in IDLE
flat_enable  out  1  enable to flatten block, one-cycle pulse
flat_vector  in  FLAT_BITS  registered output of flatten block; element e = bits [e*DATA_WIDTH +: DATA_WIDTH]
busy  out  1  high in every state except IDLE
out_data  out  LANES*DATA_WIDTH  beat payload; lane l = bits [l*DATA_WIDTH +: DATA_WIDTH]
out_keep  out  LANES  per-lane valid mask
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat when out_valid && out_ready
out_last  out  1  high with the final beat
out_beat  out  BW  index of the current beat, 0..BEATS-1
done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. On reset: state=IDLE; flat_enable, busy, out_valid, out_last, and done are 0; out_data, out_keep, out_beat, and the capture register are 0.
- Reset in any state, including mid-stream, aborts immediately. No done is pulsed and the partial stream is dropped.
- States and transitions:
  - IDLE: start=1 goes to FLAT. Otherwise the state holds.
  - FLAT: flat_enable=1 for exactly this cycle. Next state is LOAD.
  - LOAD: flat_vector is valid this cycle and is captured into the internal register at the clock edge. Beat counter is set to 0. Next state is STREAM.
  - STREAM: out_valid=1. On out_valid && out_ready, the counter increments. If the counter equals BEATS-1 when the beat is accepted, the next state is DONE.
  - DONE: done=1 for one cycle; out_valid=0. Next state is IDLE.
- start is ignored outside IDLE; no queuing. start in the DONE cycle is also ignored.
- Beat content: lane l of beat b is element b*LANES+l. Lanes where b*LANES+l ≥ N carry zero and have out_keep[l]=0. All other lanes have out_keep[l]=1.
- out_last is 1 only when out_beat = BEATS-1 and out_valid=1.
- While out_valid=1 and out_ready=0, out_data, out_keep, out_last, and out_beat are held stable.
- out_valid never drops without a handshake, except on reset.
- out_data, out_keep, and out_last are derived from the capture register and the counter. They may be combinational from registered state; there is no combinational path from out_ready to out_valid.
- Latency with out_ready held at 1:
  - start is sampled at edge 0.
  - flat_enable is high in cycle 1.
  - Capture happens at the end of cycle 2.
  - The first beat is valid in cycle 3.
  - The last beat is in cycle 3+BEATS-1.
  - done is in the following cycle.
  - IDLE is re-entered one cycle after done, where a new start is accepted.
- flat_vector is sampled only in LOAD. Changes at any other time have no effect on the stream.
- BEATS=1: STREAM lasts one accepted beat with out_last=1 and out_beat=0.

Test Plan:
- Defaults, flat_vector element e = e+1, out_ready=1, start pulse: flat_enable is high in cycle 1 only. 8 beats follow in cycles 3..10; beat 0 = {04,03,02,01}, beat 7 = {20,1F,1E,1D}; out_keep=4'hF throughout. out_last is high only on beat 7, done is high in cycle 11, and busy falls in cycle 12.
- LANES=5, same data: 7 beats. Beat 6 carries elements 30,31 in lanes 0-1 and zeros in lanes 2-4, with out_keep=5'b00011 and out_last=1.
- Backpressure: out_ready toggles 1,0,0,1,… during the stream. Each beat is held unchanged while out_ready=0, no beat is skipped or duplicated, and out_beat is monotonic 0..7.
- start re-asserted during STREAM and during DONE: ignored, with exactly one flat_enable pulse and one done per accepted start. A start one cycle after done begins a new pass.
- rst asserted while out_beat=3: the next cycle is IDLE with all outputs 0 and no done. A subsequent start restarts from beat 0.
- flat_vector changed to all-FF after LOAD: the streamed data still matches the value present in the LOAD cycle.
